// File: rtl/sap_mem_ctrl.sv
// sap_mem_ctrl: single-port synchronous memory with a write-protected monitor ROM below ROM_TOP and RAM above it.
// Latency: reads return READ_LAT edges after acceptance. Writes take effect at the accepting edge.
// Backpressure: busy is high for READ_LAT-1 cycles after each read. Requests seen while busy are dropped, never queued.
//
// Ports:
//   CLK, CLR      rising-edge clock and synchronous active-high reset (the array keeps its contents)
//   req, we       access strobe; we=1 selects a write, we=0 a read
//   address       full-width word address with no aliasing
//   wdata         write data
//   rdata         registered read data; it holds until the next read completes
//   rvalid        one-cycle pulse while rdata carries a fresh read
//   busy          a read is in flight
//   wp_err        one-cycle pulse when a ROM-region write is rejected
//   err_cnt       saturating count of rejected writes
//   rom_unlock    present only with SAP_ROM_UNLOCK_EN; while high, the ROM region is writable
//
// Optional build macro: SAP_ROM_UNLOCK_EN adds the rom_unlock input.
// The power-up array contents (mem[i] = i) are loaded by the simulation environment.

module sap_mem_ctrl #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] ROM_TOP  = ADDR_W'(16'h07FF),
    parameter int                READ_LAT = 1,
    parameter int                ERRCNT_W = 8
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
`ifdef SAP_ROM_UNLOCK_EN
    input  logic                rom_unlock,
`endif
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                busy,
    output logic                wp_err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t            state;
    logic [1:0]        lat_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_pend;    // the array is read into rdata on the edge after this is set
    logic              unlocked;
    logic              accept;
    logic              in_rom;
    logic              wr_ok;

`ifdef SAP_ROM_UNLOCK_EN
    assign unlocked = rom_unlock;
`else
    assign unlocked = 1'b0;
`endif

    // busy is a registered copy of (state == RD_WAIT), so it gates acceptance directly.
    assign accept = req && !busy && !CLR;
    assign in_rom = (address <= ROM_TOP);
    assign wr_ok  = accept && we && (!in_rom || unlocked);

    // The storage array has no reset, so CLR leaves the contents alone.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[address] <= wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state   <= IDLE;
            lat_cnt <= 2'd0;
            rd_addr <= '0;
            rd_pend <= 1'b0;
            rdata   <= '0;
            rvalid  <= 1'b0;
            busy    <= 1'b0;
            wp_err  <= 1'b0;
            err_cnt <= '0;
        end else begin
            rd_pend <= 1'b0;
            wp_err  <= 1'b0;
            rvalid  <= rd_pend;
            // The last latency stage fetches from the array. This stage alone gives
            // read-after-write for a read accepted the cycle after a write.
            if (rd_pend) begin
                rdata <= mem[rd_addr];
            end

            case (state)
                IDLE: begin
                    if (accept && we && in_rom && !unlocked) begin
                        wp_err <= 1'b1;
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + ERRCNT_W'(1);
                        end
                    end
                    if (accept && !we) begin
                        rd_addr <= address;
                        if (READ_LAT == 1) begin
                            rd_pend <= 1'b1;
                        end else begin
                            lat_cnt <= LAT_M1;
                            busy    <= 1'b1;
                            state   <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == 2'd1) begin
                        rd_pend <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sap_mem_ctrl.md
Name: sap_mem_ctrl

Overview:
- Parametrised successor to the SAP-II 64K memory: a single-port synchronous memory with a write-protected monitor-ROM region below a configurable boundary and RAM above it.
- Replaces the tri-state data bus and nCE strobe with separate write/read buses, a request strobe, configurable read latency and read-valid/busy handshaking.
- Sits between the MAR/MDR path and the storage array.
- Reports and counts rejected writes to the ROM region.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 16, address width; depth is exactly 2**ADDR_W words.
- ROM_TOP, 16'h07FF, highest ROM address; addresses 0..ROM_TOP are write-protected.
- READ_LAT, 1, read latency in cycles; legal range 1..4.
- ERRCNT_W, 8, width of the protection-error counter.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- CLR  input  1  synchronous, active-high reset.
- req  input  1  access request, sampled at the CLK edge.
- we  input  1  1 = write, 0 = read; qualified by req.
- address  input  ADDR_W  access address.
- wdata  input  DATA_W  write data.
- rdata  output  DATA_W  read data, registered.
- rvalid  output  1  one-cycle pulse; rdata valid while high.
- busy  output  1  high while a read is in flight; requests are ignored while high.
- wp_err  output  1  one-cycle pulse when a write to the ROM region is rejected.
- err_cnt  output  ERRCNT_W  saturating count of rejected writes.

Behaviour:
- Reset (CLR=1 at an edge):
  - rdata=0, rvalid=0, busy=0, wp_err=0, err_cnt=0, FSM=IDLE.
  - Array contents are NOT altered by CLR.
- Power-up (simulation initial): memory[i] = i[DATA_W-1:0] for every i in 0..2**ADDR_W-1. There is no extra location beyond the top address.
- Acceptance: a request is accepted at an edge when req=1, busy=0 and CLR=0. Requests are never queued.
- Write (we=1, accepted):
  - If address > ROM_TOP: memory[address] <= wdata at that edge; no response pulse.
  - If address <= ROM_TOP: array unchanged; wp_err=1 for the following cycle; err_cnt increments, saturating at all-ones.
  - A write never asserts busy.
- Read (we=0, accepted):
  - The address is captured at the accepting edge.
  - rdata takes memory[captured address], and rvalid=1, exactly READ_LAT edges after acceptance.
  - rvalid lasts one cycle; rdata holds its value until the next read completes.
- FSM states:
  - IDLE: accepts requests. For a read with READ_LAT>1, loads the latency counter with READ_LAT-1 and moves to RD_WAIT.
  - RD_WAIT: busy=1. The counter decrements each edge; when it reaches 1, the read completes and the FSM returns to IDLE.
  - With READ_LAT=1 the FSM stays in IDLE and back-to-back reads complete every cycle at full throughput.
- busy: high for READ_LAT-1 cycles after each accepted read. A req arriving while busy=1 is dropped silently, whether read or write.
- Read-after-write: a read accepted the cycle after a RAM write returns the new data.
- CLR mid-read: the in-flight read is abandoned and no rvalid is produced. CLR has priority over every other event at the same edge.
- Address width: address is used in full, with no aliasing. ROM_TOP is compared unsigned.

Optional Feature:
- Macro: SAP_ROM_UNLOCK_EN.
- When defined:
  - Adds an input port rom_unlock (1 bit).
  - While rom_unlock=1, writes to 0..ROM_TOP are performed like RAM writes, with no wp_err pulse and no err_cnt change. This lets the loader install the monitor program.
- When undefined: the port is absent and the ROM region is always protected.

Test Plan:
- CLR for 2 cycles, then read 16'h0003 with READ_LAT=1 -> rvalid at edge +1, rdata=8'h03; err_cnt=0.
- Write 8'h20 to 16'h0800, then read 16'h0800 on the next cycle -> rdata=8'h20.
- Write 8'h30 to 16'h0004 -> wp_err pulses one cycle, err_cnt=1; a later read of 16'h0004 returns 8'h04.
- READ_LAT=3: read 16'h0010, then issue a write to 16'h0900 while busy -> busy high 2 cycles, rvalid at edge +3 with rdata=8'h10; 16'h0900 still reads 8'h00.
- READ_LAT=3: read accepted, CLR asserted at edge +1 -> no rvalid afterwards, busy=0, rdata=0.
- 260 writes to the ROM region -> err_cnt saturates at 8'hFF. With SAP_ROM_UNLOCK_EN defined and rom_unlock=1, a write of 8'h55 to 16'h0000 reads back 8'h55.
